// File: rtl/row_len_gen_pkg.sv
// +-----------------------------------------------------------------------+
// | row_len_gen_pkg : shared types for the CSR row-length generator       |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`default_nettype none

package row_len_gen_pkg;

  localparam int DEFAULT_DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BASE  = 2'd1,
    ST_RUN   = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  typedef logic [DEFAULT_DATA_W-1:0] len_t;

endpackage

`default_nettype wire

// File: rtl/row_len_fifo.sv
// +-----------------------------------------------------------------------+
// | row_len_fifo : small synchronous FIFO with registered full/empty      |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`default_nettype none

module row_len_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count, count_nxt;
  logic             do_push, do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    count_nxt = count;
    if (do_push && !do_pop)
      count_nxt = count + CNT_ONE;
    else if (!do_push && do_pop)
      count_nxt = count - CNT_ONE;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      count <= count_nxt;
      full  <= (count_nxt == CNT_FULL);
      empty <= (count_nxt == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Masked when empty so the downstream bus reads zero whenever nothing is valid.
  assign pop_data = empty ? '0 : mem[rd_ptr];

endmodule

`default_nettype wire

// File: rtl/row_len_gen.sv
// +-----------------------------------------------------------------------+
// | row_len_gen : converts CSR row pointers into per-row non-zero counts  |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`default_nettype none

module row_len_gen
  import row_len_gen_pkg::*;
#(
  parameter int DATA_W    = DEFAULT_DATA_W,
  parameter int OUT_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic [DATA_W-1:0] row_num,
  input  logic              s_axis_rowptr_tvalid,
  output logic              s_axis_rowptr_tready,
  input  logic [DATA_W-1:0] s_axis_rowptr_tdata,
  output logic              m_axis_times_tvalid,
  input  logic              m_axis_times_tready,
  output logic [DATA_W-1:0] m_axis_times_tdata,
  output logic              m_axis_times_tlast,
  output logic              busy,
  output logic              done,
  output logic              err_nonmono
);

  state_t            state, state_nxt;
  logic [DATA_W-1:0] prev_ptr, rows_left, len;
  logic              fifo_full, fifo_empty;
  logic [DATA_W:0]   fifo_dout;
  logic              base_acc, run_acc, start_ok, drain_done, zero_done, is_last;

  // A decreasing pointer yields a zero length rather than a wrapped difference.
  assign len     = (s_axis_rowptr_tdata < prev_ptr) ? '0 : s_axis_rowptr_tdata - prev_ptr;
  assign is_last = (rows_left == DATA_W'(1));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt            = state;
    s_axis_rowptr_tready = 1'b0;
    base_acc             = 1'b0;
    run_acc              = 1'b0;
    start_ok             = 1'b0;
    drain_done           = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start && (row_num != '0)) begin
          start_ok  = 1'b1;
          state_nxt = ST_BASE;
        end
      end
      ST_BASE: begin
        s_axis_rowptr_tready = 1'b1;
        if (s_axis_rowptr_tvalid) begin
          base_acc  = 1'b1;
          state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        s_axis_rowptr_tready = !fifo_full;
        if (s_axis_rowptr_tvalid && !fifo_full) begin
          run_acc = 1'b1;
          if (is_last) state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (fifo_empty) begin
          drain_done = 1'b1;
          state_nxt  = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      prev_ptr    <= '0;
      rows_left   <= '0;
      err_nonmono <= 1'b0;
      zero_done   <= 1'b0;
    end else begin
      zero_done <= (state == ST_IDLE) && start && (row_num == '0);
      if (start_ok) begin
        rows_left   <= row_num;
        err_nonmono <= 1'b0;
      end
      if (base_acc) prev_ptr <= s_axis_rowptr_tdata;
      if (run_acc) begin
        prev_ptr  <= s_axis_rowptr_tdata;
        rows_left <= rows_left - DATA_W'(1);
        if (s_axis_rowptr_tdata < prev_ptr) err_nonmono <= 1'b1;
      end
    end
  end

  row_len_fifo #(
    .WIDTH (DATA_W + 1),
    .DEPTH (OUT_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rstn      (rstn),
    .push      (run_acc),
    .push_data ({is_last, len}),
    .pop       (m_axis_times_tready),
    .pop_data  (fifo_dout),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign m_axis_times_tvalid = !fifo_empty;
  assign m_axis_times_tdata  = fifo_dout[DATA_W-1:0];
  assign m_axis_times_tlast  = fifo_dout[DATA_W];
  assign done                = drain_done || zero_done;
  assign busy                = (state != ST_IDLE) && !drain_done;

endmodule

`default_nettype wire

// File: tb/tb_row_len_gen.sv
// +-----------------------------------------------------------------------+
// | tb_row_len_gen : directed scoreboard bench for row_len_gen            |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`default_nettype none

module tb_row_len_gen;

  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rstn;
  logic          start;
  logic [DW-1:0] row_num;
  logic          s_tvalid;
  logic          s_tready;
  logic [DW-1:0] s_tdata;
  logic          m_tvalid;
  logic          m_tready;
  logic [DW-1:0] m_tdata;
  logic          m_tlast;
  logic          busy, done, err;

  int passed = 0;
  int total  = 0;
  int beats  = 0;
  int dones  = 0;
  int rmode  = 0;
  logic [DW:0] sb[$];

  row_len_gen #(.DATA_W(DW), .OUT_DEPTH(2)) dut (
    .clk                  (clk),
    .rstn                 (rstn),
    .start                (start),
    .row_num              (row_num),
    .s_axis_rowptr_tvalid (s_tvalid),
    .s_axis_rowptr_tready (s_tready),
    .s_axis_rowptr_tdata  (s_tdata),
    .m_axis_times_tvalid  (m_tvalid),
    .m_axis_times_tready  (m_tready),
    .m_axis_times_tdata   (m_tdata),
    .m_axis_times_tlast   (m_tlast),
    .busy                 (busy),
    .done                 (done),
    .err_nonmono          (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
  endtask

  // Downstream ready pattern: 0 always ready, 1 toggling, 2 held low.
  initial begin
    m_tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rmode)
        0:       m_tready = 1'b1;
        1:       m_tready = ~m_tready;
        default: m_tready = 1'b0;
      endcase
    end
  end

  // Output monitor: scoreboard compare, stall stability, done after tlast.
  initial begin : monitor
    logic        stall_prev;
    logic        last_prev;
    logic [DW:0] stall_word;
    logic [DW:0] expw;
    stall_prev = 1'b0;
    last_prev  = 1'b0;
    stall_word = '0;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        stall_prev = 1'b0;
        last_prev  = 1'b0;
      end else begin
        if (last_prev) chk("done_after_tlast", 64'(done), 64'd1);
        last_prev = 1'b0;
        if (stall_prev) begin
          chk("stall_valid", 64'(m_tvalid), 64'd1);
          chk("stall_data", 64'({m_tlast, m_tdata}), 64'(stall_word));
        end
        if (m_tvalid && m_tready) begin
          if (sb.size() == 0) begin
            chk("unexpected_beat", 64'(m_tdata), 64'hFFFF_FFFF_FFFF_FFFF);
          end else begin
            expw = sb.pop_front();
            chk("beat", 64'({m_tlast, m_tdata}), 64'(expw));
          end
          beats++;
          last_prev = m_tlast;
        end
        stall_prev = m_tvalid && !m_tready;
        stall_word = {m_tlast, m_tdata};
        if (done) dones++;
      end
    end
  end

  task automatic start_pass(input logic [DW-1:0] n);
    start   = 1'b1;
    row_num = n;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic send(input logic [DW-1:0] w);
    int   n;
    logic hs;
    n  = 0;
    hs = 1'b0;
    s_tvalid = 1'b1;
    s_tdata  = w;
    while (!hs && n < 200) begin
      @(negedge clk);
      hs = s_tready;
      @(posedge clk);
      #1;
      n++;
    end
    s_tvalid = 1'b0;
    if (!hs) chk("send_timeout", 64'd0, 64'd1);
  endtask

  task automatic expect_lens(input logic [DW-1:0] p[]);
    for (int i = 1; i < p.size(); i++)
      sb.push_back({(i == p.size() - 1), (p[i] >= p[i-1]) ? p[i] - p[i-1] : DW'(0)});
  endtask

  task automatic wait_done();
    int n;
    int d0;
    n  = 0;
    d0 = dones;
    while (dones == d0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("done_seen", 64'(dones != d0), 64'd1);
    chk("busy_after_done", 64'(busy), 64'd0);
    chk("sb_empty", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    logic [DW-1:0] p[];
    int n;
    int b0;
    int d0;
    rstn = 1'b0; start = 1'b0; row_num = '0; s_tvalid = 1'b0; s_tdata = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_tvalid", 64'(m_tvalid), 64'd0);
    chk("rst_tdata", 64'(m_tdata), 64'd0);
    chk("rst_tlast", 64'(m_tlast), 64'd0);
    chk("rst_s_tready", 64'(s_tready), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    rstn = 1'b1;
    @(posedge clk);
    #1;

    // Basic pass with a zero-length row, plus first-beat latency.
    rmode = 0;
    p = '{0, 4, 4, 9};
    expect_lens(p);
    start_pass(3);
    @(negedge clk);
    chk("busy_after_start", 64'(busy), 64'd1);
    @(posedge clk);
    #1;
    send(p[0]);
    send(p[1]);
    @(negedge clk);
    chk("latency_valid", 64'(m_tvalid), 64'd1);
    @(posedge clk);
    #1;
    send(p[2]);
    send(p[3]);
    wait_done();

    // Toggling downstream ready; a start during the pass must be ignored.
    rmode = 1;
    p = '{10, 12, 15, 16, 20};
    expect_lens(p);
    start_pass(4);
    send(p[0]);
    send(p[1]);
    start = 1'b1; row_num = 3;
    send(p[2]);
    start = 1'b0;
    send(p[3]);
    send(p[4]);
    wait_done();

    // Non-monotonic pointer: clamped length and sticky error.
    rmode = 0;
    p = '{8, 5, 7};
    expect_lens(p);
    start_pass(2);
    send(p[0]);
    send(p[1]);
    send(p[2]);
    wait_done();
    chk("err_set", 64'(err), 64'd1);
    repeat (3) @(posedge clk);
    #1;
    chk("err_held", 64'(err), 64'd1);

    // Reset mid-pass after three rows have gone out.
    start_pass(8);
    chk("err_cleared", 64'(err), 64'd0);
    sb.push_back({1'b0, 32'd1});
    sb.push_back({1'b0, 32'd2});
    sb.push_back({1'b0, 32'd3});
    b0 = beats;
    send(0); send(1); send(3); send(6);
    n = 0;
    while (beats < b0 + 3 && n < 50) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("three_rows_out", 64'(beats - b0), 64'd3);
    d0 = dones;
    s_tvalid = 1'b1;
    s_tdata  = 32'd10;
    rstn = 1'b0;
    #1;
    chk("mid_rst_tvalid", 64'(m_tvalid), 64'd0);
    chk("mid_rst_tdata", 64'(m_tdata), 64'd0);
    chk("mid_rst_tlast", 64'(m_tlast), 64'd0);
    chk("mid_rst_s_tready", 64'(s_tready), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_done", 64'(done), 64'd0);
    s_tvalid = 1'b0;
    sb.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    chk("post_rst_busy", 64'(busy), 64'd0);
    chk("post_rst_s_tready", 64'(s_tready), 64'd0);
    chk("post_rst_no_done", 64'(dones - d0), 64'd0);
    @(posedge clk);
    #1;
    p = '{0, 7};
    expect_lens(p);
    start_pass(1);
    send(p[0]);
    send(p[1]);
    wait_done();

    // Zero-row start: immediate done, nothing consumed.
    b0 = beats;
    s_tvalid = 1'b1;
    s_tdata  = 32'd99;
    start = 1'b1;
    row_num = 0;
    @(negedge clk);
    chk("zero_s_tready", 64'(s_tready), 64'd0);
    chk("zero_busy", 64'(busy), 64'd0);
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    chk("zero_done", 64'(done), 64'd1);
    chk("zero_busy_done", 64'(busy), 64'd0);
    chk("zero_s_tready2", 64'(s_tready), 64'd0);
    @(negedge clk);
    chk("zero_done_pulse", 64'(done), 64'd0);
    chk("zero_no_beats", 64'(beats - b0), 64'd0);
    s_tvalid = 1'b0;
    @(posedge clk);
    #1;

    // Downstream held off: input back-pressure after the buffer fills.
    rmode = 2;
    p = '{0, 1, 3, 6, 10, 15};
    expect_lens(p);
    start_pass(5);
    send(p[0]);
    send(p[1]);
    send(p[2]);
    s_tvalid = 1'b1;
    s_tdata  = p[3];
    repeat (8) @(negedge clk);
    chk("backpressure_s_tready", 64'(s_tready), 64'd0);
    chk("backpressure_full_valid", 64'(m_tvalid), 64'd1);
    rmode = 0;
    @(posedge clk);
    #1;
    send(p[3]);
    send(p[4]);
    send(p[5]);
    wait_done();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire

// File: doc/row_len_gen.md
ROW_LEN_GEN -- requirements
Module: row_len_gen

Interface
REQ-001 Parameter DATA_W, default 32, width of row-pointer and row-length words.
REQ-002 Parameter OUT_DEPTH, default 2, output buffer entries (power of 2, >=2).
REQ-003 clk  input  1  sole clock; all logic on rising edge.
REQ-004 rstn  input  1  asynchronous active-low reset.
REQ-005 start  input  1  one-cycle pulse; begins a matrix pass, sampled only in IDLE.
REQ-006 row_num  input  DATA_W  number of rows for the pass, captured on start.
REQ-007 s_axis_rowptr_tvalid / _tready / _tdata[DATA_W]  AXIS slave, CSR row-pointer words row_ptr[0..row_num].
REQ-008 m_axis_times_tvalid / _tready / _tdata[DATA_W] / _tlast  AXIS master, per-row non-zero count to the clear controller.
REQ-009 busy  output  1  high from accepted start until done.
REQ-010 done  output  1  one-cycle pulse after last row length is accepted downstream.
REQ-011 err_nonmono  output  1  sticky; set when a row pointer is below its predecessor.

Function
REQ-012 FSM states IDLE, BASE, RUN, DRAIN; reset state IDLE.
REQ-013 IDLE: s_axis_rowptr_tready=0; start with row_num!=0 -> BASE, captures row_num, clears err_nonmono; start with row_num=0 -> stays IDLE, pulses done next cycle.
REQ-014 BASE: tready=1; first accepted word stored as prev_ptr, no output produced; -> RUN.
REQ-015 RUN: tready = buffer not full; each accepted word p pushes len = p - prev_ptr, then prev_ptr<=p, rows_left decrements.
REQ-016 Length arithmetic modulo 2^DATA_W is forbidden: if p < prev_ptr, push len=0 and set err_nonmono; prev_ptr still updates to p.
REQ-017 Zero-length rows (p == prev_ptr) SHALL be emitted with tdata=0, never dropped.
REQ-018 Entry for the final row (rows_left==1 at accept) SHALL carry tlast=1; FSM -> DRAIN, tready=0.
REQ-019 DRAIN: waits until buffer empty, pulses done, -> IDLE, busy drops same cycle as done.
REQ-020 Latency: word accepted cycle N -> m_axis_times_tvalid high cycle N+1 when buffer was empty.
REQ-021 Throughput: one row per cycle sustained while m_axis_times_tready=1; no combinational path tready(out) -> tready(in).
REQ-022 m_axis_times_tdata/tlast SHALL be stable while tvalid=1 and tready=0.
REQ-023 Simultaneous push and pop on a full buffer is not allowed (tready in depends on registered full only); push and pop on non-full, non-empty buffer both occur.
REQ-024 start while busy SHALL be ignored.
REQ-025 Input words beyond row_num+1 are not consumed (tready=0 in DRAIN/IDLE).

Reset
REQ-026 rstn low, any cycle: FSM -> IDLE, buffer emptied, m_axis_times_tvalid=0, tlast=0, tdata=0, s_axis_rowptr_tready=0, busy=0, done=0, err_nonmono=0, prev_ptr=0, rows_left=0.
REQ-027 Reset mid-pass discards pending rows; no done pulse; first cycle after release is IDLE.

Structure
REQ-028 Shared package holds DATA_W default, FSM state encoding, and len-width typedef, reused by the clear controller.
REQ-029 One sub-module row_len_fifo (synchronous FIFO, OUT_DEPTH x (DATA_W+1), registered full/empty, async active-low reset).

Verification
REQ-030 row_num=3, row_ptr {0,4,4,9}, tready=1 -> times 4,0,5, tlast on 5, done one cycle after last accept.
REQ-031 row_num=4, row_ptr {10,12,15,16,20}, m tready toggling 1/0 each cycle -> 2,3,1,4 in order, data stable while stalled, no loss.
REQ-032 row_num=2, row_ptr {8,5,7} -> times 0,2, err_nonmono=1 and held until next start.
REQ-033 start with row_num=0 -> no times beat, no rowptr accepted, done pulse, busy stays 0.
REQ-034 row_num=8, reset asserted after 3 rows output -> all outputs at reset values same cycle; new pass row_num=1 {0,7} -> single beat 7 with tlast.
REQ-035 m tready=0 for 10 cycles during RUN -> s tready drops after OUT_DEPTH words buffered, resumes on drain, sequence intact.
